aes_vector_runner: RTL
======================

# aes_vector_runner

Synthesizable self-checking driver for `aes_cipher_top`: fetches known-answer vectors (key, plaintext, expected ciphertext) from an external synchronous ROM and issues each to the AES core with a one-cycle `ld` pulse. It waits for `done` (with a timeout), compares `text_out` against the expected ciphertext and accumulates pass/fail statistics. It replaces single-vector, hand-sequenced stimulus with a parametrised, multi-vector, optionally looping engine usable in simulation and on FPGA bring-up.

## Interface
- NUM_VEC, 16, number of vectors in ROM (1..2^ADDR_W)
- ADDR_W, 4, ROM address width
- CNT_W, 16, pass/fail counter width
- TIMEOUT, 64, max cycles in WAIT before declaring a timeout (>=1)
- LOOP, 0, 1 = wrap to vector 0 after the last vector and run until `stop`

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin run; honoured only in IDLE or FIN
- stop  in  1  LOOP mode: finish the current vector, then go to FIN
- vec_addr  out  ADDR_W  ROM address, registered
- vec_key, vec_pt, vec_ct  in  128 each  ROM data; 1-cycle read latency
- aes_ld  out  1  load pulse to AES core
- aes_key, aes_text_in  out  128 each  held stable from LOAD through end of WAIT
- aes_done  in  1  AES completion
- aes_text_out  in  128  AES result, valid while aes_done=1
- busy  out  1  high in every state except IDLE/FIN
- finished  out  1  level, high in FIN
- pass_cnt, fail_cnt  out  CNT_W each  saturating counters
- timeout_err  out  1  sticky; set on any timeout during the run
- first_fail_idx  out  ADDR_W  index of first failing vector; all-ones when none

## Operation
- States: IDLE, FETCH, LATCH, LOAD, WAIT, CHECK, FIN.
- IDLE/FIN + start: clear counters, timeout_err, first_fail_idx (all-ones), idx=0, vec_addr=0; go FETCH.
- FETCH: ROM samples vec_addr at the closing edge; go LATCH.
- LATCH: register vec_key→aes_key, vec_pt→aes_text_in, vec_ct→exp_ct; go LOAD.
- LOAD: aes_ld=1 for exactly this cycle; clear timer; go WAIT.
- WAIT: aes_done=1 → capture match = (aes_text_out == exp_ct); go CHECK. Else timer++; timer==TIMEOUT-1 with aes_done=0 → match=0, timeout_err=1, go CHECK.
- CHECK: match → pass_cnt++, else fail_cnt++ (both saturate at all-ones); on first failure first_fail_idx=idx.
  - idx<NUM_VEC-1 and not stopping: idx++, vec_addr=idx+1, go FETCH.
  - idx==NUM_VEC-1: LOOP=0 → FIN; LOOP=1 → idx=0, vec_addr=0, FETCH.
  - stopping (stop seen any cycle since LOAD, latched): go FIN.
- FIN: results held until start or rst.
- aes_done outside WAIT ignored. aes_done in the timeout cycle: done wins (normal compare, no timeout).
- start while busy ignored; stop in LOOP=0 still shortens the run after the current vector.

## Timing
- Reset (rst=1 at edge): state IDLE, all outputs 0 except first_fail_idx = all-ones; aes_ld deasserts at that edge even mid-run; partial results discarded.
- start sampled at edge 0 → FETCH cycle 1, LATCH 2, LOAD 3 (aes_ld high), WAIT from 4.
- Per vector: 4 + D cycles, where D = WAIT cycles up to and including the aes_done cycle (TIMEOUT if timed out).
- Counters/first_fail_idx update at the edge ending CHECK; finished rises the cycle after the last CHECK.
- aes_key/aes_text_in change only at the edge ending LATCH.

## Test plan
- Single vector NUM_VEC=1, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, ct 69c4e0d86a7b0430d8cdb78070b4c55a → pass_cnt=1, fail_cnt=0, finished, first_fail_idx=all-ones; aes_ld high exactly 1 cycle, at cycle 3.
- Two vectors, second key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, ROM ct corrupted (expected 3925841d02dc09fbdc118597196a0b32, stored ...32 → ...33) → pass=1, fail=1, first_fail_idx=1.
- AES stub never asserts done, TIMEOUT=8 → each vector takes 12 cycles, fail_cnt=NUM_VEC, timeout_err=1; stub asserting done exactly in cycle 8 of WAIT → pass, no timeout.
- LOOP=1, NUM_VEC=2, stop pulsed during third vector's WAIT → FIN after third CHECK, pass_cnt=3, vec_addr wrapped 1→0.
- rst asserted during WAIT → next cycle IDLE, aes_ld=0, counters 0; a new start reruns cleanly; start pulsed while busy has no effect.
- CNT_W=2, 5 passing vectors → pass_cnt saturates at 3.

Source files
------------

// File: rtl/aes_vector_runner.sv
// aes_vector_runner: drives known-answer vectors from a synchronous ROM into an
// AES core, one vector at a time. It waits for completion (bounded by a timeout),
// compares the result and accumulates saturating pass/fail statistics. It can
// optionally loop over the vector set until stopped.
module aes_vector_runner #(
   parameter int NUM_VEC = 16,
   parameter int ADDR_W  = 4,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64,
   parameter int LOOP    = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   output logic [ADDR_W-1:0]  vec_addr,
   input  logic [127:0]       vec_key,
   input  logic [127:0]       vec_pt,
   input  logic [127:0]       vec_ct,
   output logic               aes_ld,
   output logic [127:0]       aes_key,
   output logic [127:0]       aes_text_in,
   input  logic               aes_done,
   input  logic [127:0]       aes_text_out,
   output logic               busy,
   output logic               finished,
   output logic [CNT_W-1:0]   pass_cnt,
   output logic [CNT_W-1:0]   fail_cnt,
   output logic               timeout_err,
   output logic [ADDR_W-1:0]  first_fail_idx
);

   // Timer only needs to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_LOAD,
      S_WAIT,
      S_CHECK,
      S_FIN
   } state_t;

   state_t             state;
   logic [ADDR_W-1:0]  idx;
   logic [TMR_W-1:0]   timer;
   logic [127:0]       exp_ct;
   logic               match;
   logic               stop_lat;

   // Counters stick at all-ones instead of wrapping so long loop runs stay meaningful.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Expected ciphertext is pure data; it is only consulted after LATCH has loaded it.
   always_ff @(posedge clk) begin
      if (state == S_LATCH) begin
         exp_ct <= vec_ct;
      end
   end

   // Main sequencer: fetch, latch, load, wait, check, then next vector or finish.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         vec_addr       <= '0;
         aes_ld         <= 1'b0;
         aes_key        <= '0;
         aes_text_in    <= '0;
         busy           <= 1'b0;
         finished       <= 1'b0;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         timeout_err    <= 1'b0;
         first_fail_idx <= '1;
         idx            <= '0;
         timer          <= '0;
         match          <= 1'b0;
         stop_lat       <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_FIN: begin
               if (start) begin
                  pass_cnt       <= '0;
                  fail_cnt       <= '0;
                  timeout_err    <= 1'b0;
                  first_fail_idx <= '1;
                  idx            <= '0;
                  vec_addr       <= '0;
                  stop_lat       <= 1'b0;
                  busy           <= 1'b1;
                  finished       <= 1'b0;
                  state          <= S_FETCH;
               end
            end

            // ROM captures vec_addr at the edge closing this cycle.
            S_FETCH: begin
               state <= S_LATCH;
            end

            // ROM data is valid now; hold it on the core inputs until the next vector.
            S_LATCH: begin
               aes_key     <= vec_key;
               aes_text_in <= vec_pt;
               aes_ld      <= 1'b1;
               state       <= S_LOAD;
            end

            S_LOAD: begin
               aes_ld   <= 1'b0;
               timer    <= '0;
               stop_lat <= stop;
               state    <= S_WAIT;
            end

            // A done in the final timeout cycle is treated as a normal completion.
            S_WAIT: begin
               stop_lat <= stop_lat | stop;
               if (aes_done) begin
                  match <= (aes_text_out == exp_ct);
                  state <= S_CHECK;
               end else if (timer == TMR_LAST) begin
                  match       <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= S_CHECK;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            S_CHECK: begin
               if (match) begin
                  pass_cnt <= sat_inc(pass_cnt);
               end else begin
                  fail_cnt <= sat_inc(fail_cnt);
                  // fail_cnt saturates rather than wraps, so zero means no earlier failure.
                  if (fail_cnt == '0) begin
                     first_fail_idx <= idx;
                  end
               end
               if (stop_lat | stop) begin
                  stop_lat <= 1'b0;
                  busy     <= 1'b0;
                  finished <= 1'b1;
                  state    <= S_FIN;
               end else if (idx != LAST_IDX) begin
                  idx      <= idx + 1'b1;
                  vec_addr <= idx + 1'b1;
                  state    <= S_FETCH;
               end else if (LOOP != 0) begin
                  idx      <= '0;
                  vec_addr <= '0;
                  state    <= S_FETCH;
               end else begin
                  busy     <= 1'b0;
                  finished <= 1'b1;
                  state    <= S_FIN;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
